// File: rtl/cpu_pkg.sv
// Shared types for the CPU front end: fetch buffer entry, fetch FSM states
// and the opcode field position consumed by the main control unit.
package cpu_pkg;

  localparam int INSTR_W    = 32;
  localparam int PC_W       = 64;
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 21;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    REDIR = 2'd2
  } fetch_state_t;

  function automatic logic [OPCODE_MSB-OPCODE_LSB:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO holding fetched {pc, instr} entries; the head is
// read straight from registered storage.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  input  logic             flush,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count
);

  fetch_entry_t     mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Qualify push/pop against the current fill level.
  always_comb begin
    do_push_s = push & (count_r != CNT_W'(DEPTH));
    do_pop_s  = pop & (count_r != {CNT_W{1'b0}});
  end

  // Storage, pointers and occupancy; flush drops everything buffered.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch front end: owns the PC, issues credit-limited requests to a
// one-cycle instruction memory and hands buffered words to decode.
module instruction_fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_rvalid,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [31:0]       if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic [10:0]       if_opcode
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_state_t      state_r;
  fetch_state_t      next_state_s;
  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] req_pc_r;
  logic              inflight_r;
  logic [ADDR_W-1:0] target_s;
  logic              req_s;
  logic              pop_s;
  logic              push_s;
  logic              valid_s;
  logic [CNT_W:0]    credit_s;
  logic [CNT_W-1:0]  count_s;
  fetch_entry_t      push_data_s;
  fetch_entry_t      head_s;
  logic              unused_tgt_s;

  assign target_s     = {br_target[ADDR_W-1:2], 2'b00};
  assign unused_tgt_s = ^br_target[1:0];

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= BOOT;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    next_state_s = BOOT;
    case (state_r)
      BOOT:    next_state_s = RUN;
      RUN:     next_state_s = br_taken ? REDIR : RUN;
      REDIR:   next_state_s = br_taken ? REDIR : RUN;
      default: next_state_s = BOOT;
    endcase
  end

  // FSM outputs: handshake, credit-limited request and response acceptance.
  // Responses are only kept in RUN, so anything returning in BOOT (after a
  // reset) or REDIR (after a redirect) belongs to a dead stream.
  always_comb begin
    valid_s  = (count_s != {CNT_W{1'b0}}) & ~br_taken;
    pop_s    = valid_s & if_ready;
    credit_s = {1'b0, count_s} + {{CNT_W{1'b0}}, inflight_r} - {{CNT_W{1'b0}}, pop_s};
    req_s    = (state_r != BOOT) & ~br_taken & (credit_s < (CNT_W + 1)'(DEPTH));
    push_s   = imem_rvalid & (state_r == RUN) & ~br_taken;
  end

  // PC, in-flight flag and the address of the outstanding request.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r       <= RESET_PC;
      req_pc_r   <= {ADDR_W{1'b0}};
      inflight_r <= 1'b0;
    end else begin
      if (br_taken) begin
        pc_r <= target_s;
      end else if (req_s) begin
        pc_r <= pc_r + ADDR_W'(4);
      end else begin
        pc_r <= pc_r;
      end
      inflight_r <= req_s;
      if (req_s) begin
        req_pc_r <= pc_r;
      end
    end
  end

  assign push_data_s.pc    = PC_W'(req_pc_r);
  assign push_data_s.instr = imem_rdata;

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push_s),
    .push_data(push_data_s),
    .pop      (pop_s),
    .flush    (br_taken),
    .head     (head_s),
    .count    (count_s)
  );

  assign imem_req  = req_s;
  assign imem_addr = pc_r;
  assign if_valid  = valid_s;
  assign if_instr  = head_s.instr;
  assign if_pc     = head_s.pc[ADDR_W-1:0];
  assign if_opcode = opcode_of(head_s.instr);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: per-cycle vector table,
// delivery scoreboard, plus a separate instance for PC wrap-around.
module tb_instruction_fetch_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, imem_req, imem_rvalid, br_taken, if_valid, if_ready;
  logic [63:0] imem_addr, br_target, if_pc;
  logic [31:0] imem_rdata, if_instr;
  logic [10:0] if_opcode;

  logic        w_rst, w_imem_req, w_imem_rvalid, w_br_taken, w_if_valid, w_if_ready;
  logic [63:0] w_imem_addr, w_br_target, w_if_pc;
  logic [31:0] w_imem_rdata, w_if_instr;
  logic [10:0] w_if_opcode;

  instruction_fetch_unit #(.ADDR_W(64), .RESET_PC(64'h0), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid), .br_taken(br_taken),
    .br_target(br_target), .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc), .if_opcode(if_opcode)
  );

  instruction_fetch_unit #(.ADDR_W(64), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC), .DEPTH(2)) dut_w (
    .clk(clk), .rst(w_rst), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
    .imem_rdata(w_imem_rdata), .imem_rvalid(w_imem_rvalid), .br_taken(w_br_taken),
    .br_target(w_br_target), .if_valid(w_if_valid), .if_ready(w_if_ready),
    .if_instr(w_if_instr), .if_pc(w_if_pc), .if_opcode(w_if_opcode)
  );

  // Synchronous instruction memory: word = 0x8B000000 | addr, one cycle later.
  initial begin
    imem_rvalid = 1'b0;
    w_imem_rvalid = 1'b0;
    imem_rdata = 32'h0;
    w_imem_rdata = 32'h0;
  end
  always @(posedge clk) begin
    imem_rvalid   <= imem_req;
    imem_rdata    <= 32'h8B00_0000 | imem_addr[31:0];
    w_imem_rvalid <= w_imem_req;
    w_imem_rdata  <= 32'h8B00_0000 | w_imem_addr[31:0];
  end

  int checks = 0;
  int passes = 0;
  logic [63:0] exp_q[$];

  function automatic logic [31:0] exp_instr(input logic [63:0] pc);
    return 32'h8B00_0000 | pc[31:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Scoreboard side: every accepted head is matched against the next expected pc.
  task automatic sample();
    logic [63:0] e;
    logic [31:0] ei;
    if (!rst) begin
      if (if_valid && if_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_delivery: got pc %h, expected no delivery", if_pc);
        end else begin
          e  = exp_q.pop_front();
          ei = exp_instr(e);
          check("sb_pc", if_pc, e);
          check("sb_instr", {32'h0, if_instr}, {32'h0, ei});
          check("sb_opcode", {53'h0, if_opcode}, {53'h0, ei[31:21]});
        end
      end
      check("no_push_when_full", {63'h0, dut.push_s & (dut.count_s >= 2'd2)}, 64'h0);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        br;
    logic [63:0] tgt;
    logic        req;
    logic [63:0] addr;
    logic        valid;
    logic [63:0] pc;
  } vec_t;
  vec_t vecs[$];

  task automatic v(input logic r, input logic rdy, input logic br, input logic [63:0] tgt,
                   input logic req, input logic [63:0] addr, input logic valid, input logic [63:0] pc);
    vec_t t;
    t.rst = r; t.rdy = rdy; t.br = br; t.tgt = tgt;
    t.req = req; t.addr = addr; t.valid = valid; t.pc = pc;
    vecs.push_back(t);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] got[$];
    logic [10:0] op0;
    logic [31:0] wi;

    rst = 1'b1; if_ready = 1'b1; br_taken = 1'b0; br_target = 64'h0;
    w_rst = 1'b1; w_if_ready = 1'b1; w_br_taken = 1'b0; w_br_target = 64'h0;

    // rst, rdy, br, tgt,      req, addr,    valid, pc
    v(0, 1, 0, 64'h0,   0, 64'h0,   0, 64'h0);    // BOOT
    v(0, 1, 0, 64'h0,   1, 64'h0,   0, 64'h0);
    v(0, 1, 0, 64'h0,   1, 64'h4,   0, 64'h0);
    v(0, 1, 0, 64'h0,   1, 64'h8,   1, 64'h0);
    v(0, 1, 0, 64'h0,   1, 64'hC,   1, 64'h4);
    v(0, 1, 0, 64'h0,   1, 64'h10,  1, 64'h8);
    v(0, 1, 1, 64'h103, 0, 64'h0,   0, 64'h0);    // redirect, 0x10 response flushed
    v(0, 1, 0, 64'h0,   1, 64'h100, 0, 64'h0);
    v(0, 1, 0, 64'h0,   1, 64'h104, 0, 64'h0);
    v(0, 1, 0, 64'h0,   1, 64'h108, 1, 64'h100);
    v(0, 1, 0, 64'h0,   1, 64'h10C, 1, 64'h104);
    v(0, 1, 1, 64'h200, 0, 64'h0,   0, 64'h0);    // back-to-back redirects
    v(0, 1, 1, 64'h300, 0, 64'h0,   0, 64'h0);
    v(0, 1, 0, 64'h0,   1, 64'h300, 0, 64'h0);
    v(0, 1, 0, 64'h0,   1, 64'h304, 0, 64'h0);
    v(0, 1, 0, 64'h0,   1, 64'h308, 1, 64'h300);
    v(0, 1, 0, 64'h0,   1, 64'h30C, 1, 64'h304);
    v(0, 0, 0, 64'h0,   0, 64'h0,   1, 64'h308);  // fill to two entries
    v(1, 1, 0, 64'h0,   1, 64'h310, 1, 64'h308);  // reset with 0x310 going out
    v(0, 0, 0, 64'h0,   0, 64'h0,   0, 64'h0);    // BOOT, stale response dropped
    v(0, 0, 0, 64'h0,   1, 64'h0,   0, 64'h0);
    v(0, 0, 0, 64'h0,   1, 64'h4,   0, 64'h0);
    v(0, 0, 0, 64'h0,   0, 64'h0,   1, 64'h0);    // credit exhausted
    v(0, 0, 0, 64'h0,   0, 64'h0,   1, 64'h0);
    v(0, 0, 0, 64'h0,   0, 64'h0,   1, 64'h0);
    v(0, 0, 0, 64'h0,   0, 64'h0,   1, 64'h0);
    v(0, 1, 0, 64'h0,   1, 64'h8,   1, 64'h0);    // release
    v(0, 1, 0, 64'h0,   1, 64'hC,   1, 64'h4);
    v(0, 1, 0, 64'h0,   1, 64'h10,  1, 64'h8);
    v(0, 1, 0, 64'h0,   1, 64'h14,  1, 64'hC);

    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_imem_req", {63'h0, imem_req}, 64'h0);
    check("rst_if_valid", {63'h0, if_valid}, 64'h0);
    check("rst_imem_addr", imem_addr, 64'h0);
    check("rst_if_pc", if_pc, 64'h0);
    check("rst_if_instr", {32'h0, if_instr}, 64'h0);
    check("rst_if_opcode", {53'h0, if_opcode}, 64'h0);
    check("rst_wrap_addr", w_imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      rst       = vecs[i].rst;
      if_ready  = vecs[i].rdy;
      br_taken  = vecs[i].br;
      br_target = vecs[i].tgt;
      if (!vecs[i].rst && vecs[i].rdy && vecs[i].valid) exp_q.push_back(vecs[i].pc);
      @(negedge clk);
      check($sformatf("row%0d_req", i), {63'h0, imem_req}, {63'h0, vecs[i].req});
      if (vecs[i].req) check($sformatf("row%0d_addr", i), imem_addr, vecs[i].addr);
      check($sformatf("row%0d_valid", i), {63'h0, if_valid}, {63'h0, vecs[i].valid});
      if (vecs[i].valid) check($sformatf("row%0d_pc", i), if_pc, vecs[i].pc);
      sample();
      @(posedge clk);
      #1;
    end
    check("sb_all_delivered", 64'(exp_q.size()), 64'h0);

    // Wrap-around instance: first two deliveries straddle address zero.
    w_rst = 1'b0;
    op0 = 11'h0;
    for (int k = 0; k < 16 && got.size() < 2; k++) begin
      @(negedge clk);
      if (w_if_valid && w_if_ready) begin
        got.push_back(w_if_pc);
        if (got.size() == 1) op0 = w_if_opcode;
      end
      @(posedge clk);
      #1;
    end
    check("wrap_delivered_count", 64'(got.size()), 64'd2);
    if (got.size() >= 2) begin
      check("wrap_pc0", got[0], 64'hFFFF_FFFF_FFFF_FFFC);
      check("wrap_pc1", got[1], 64'h0);
    end
    wi = exp_instr(64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_opcode0", {53'h0, op0}, {53'h0, wi[31:21]});

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
